// File: rtl/csrm_port_arb_pkg.sv
// Shared types for the machine CSR port arbiter: configuration record,
// arbitration state encoding and the debug-win decision.
package csrm_port_arb_pkg;

   typedef struct packed {
      int XLEN;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{XLEN: 32};

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      ACCESS,
      RESP
   } csrm_arb_state_t;

   // A trap always blocks debug; otherwise debug goes when the pipeline is
   // quiet or when it has been starved long enough.
   function automatic logic dbg_wins(input logic pipe_req,
                                     input logic trap,
                                     input logic starved);
      return ~trap & (~pipe_req | starved);
   endfunction

endpackage

// File: rtl/csrm_port_arb.sv
// Arbiter for the machine CSR file port: pipeline has priority, a debug agent
// gets through via a request/response handshake with bounded starvation.
module csrm_port_arb
   import csrm_port_arb_pkg::*;
#(
   parameter cvw_t P            = CVW_DEFAULT,
   parameter int   STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                CSRReqM,
   input  logic                CSRWriteReqM,
   input  logic [11:0]         CSRAdrReqM,
   input  logic [P.XLEN-1:0]   CSRWriteValReqM,
   input  logic                MTrapM,
   input  logic [P.XLEN-1:0]   CSRMReadValM,
   input  logic                IllegalCSRMAccessM,
   input  logic                IllegalCSRMWriteReadonlyM,
   output logic [11:0]         CSRAdrM,
   output logic [P.XLEN-1:0]   CSRWriteValM,
   output logic                UngatedCSRMWriteM,
   output logic                CSRMWriteM,
   output logic                CSRArbStallM,
   input  logic                DbgReq,
   output logic                DbgReady,
   input  logic                DbgWrite,
   input  logic [11:0]         DbgAdr,
   input  logic [P.XLEN-1:0]   DbgWdata,
   output logic                DbgRspValid,
   input  logic                DbgRspReady,
   output logic [P.XLEN-1:0]   DbgRspData,
   output logic                DbgRspErr
);

   localparam int XLEN = P.XLEN;
   localparam int CW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   csrm_arb_state_t state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cap_write_q, cap_write_d;
   logic [11:0]     cap_adr_q, cap_adr_d;
   logic [XLEN-1:0] cap_wdata_q, cap_wdata_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic            cap_en, rsp_en, illegal;

   assign illegal = IllegalCSRMAccessM | IllegalCSRMWriteReadonlyM;

   always_comb begin
      state_d           = state_q;
      cnt_d             = cnt_q;
      cap_en            = 1'b0;
      rsp_en            = 1'b0;
      DbgReady          = 1'b0;
      DbgRspValid       = 1'b0;
      CSRAdrM           = CSRAdrReqM;
      CSRWriteValM      = CSRWriteValReqM;
      UngatedCSRMWriteM = CSRWriteReqM;
      CSRMWriteM        = CSRWriteReqM & CSRReqM;
      CSRArbStallM      = 1'b0;
      case (state_q)
         IDLE: begin
            DbgReady = 1'b1;
            if (DbgReq) begin
               cap_en  = 1'b1;
               cnt_d   = '0;
               state_d = PEND;
            end
         end
         PEND: begin
            if (dbg_wins(CSRReqM, MTrapM, cnt_q == LIMIT_C)) begin
               state_d = ACCESS;
            end else if (~MTrapM && (cnt_q != LIMIT_C)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ACCESS: begin
            CSRAdrM      = cap_adr_q;
            CSRWriteValM = cap_wdata_q;
            CSRArbStallM = CSRReqM;
            // A trap owns the file this cycle; retry later with the count kept
            if (MTrapM) begin
               UngatedCSRMWriteM = 1'b0;
               CSRMWriteM        = 1'b0;
               state_d           = PEND;
            end else begin
               UngatedCSRMWriteM = cap_write_q;
               CSRMWriteM        = cap_write_q & ~illegal;
               rsp_en            = 1'b1;
               state_d           = RESP;
            end
         end
         RESP: begin
            DbgRspValid = 1'b1;
            if (DbgRspReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cap_write_d = cap_en ? DbgWrite     : cap_write_q;
      cap_adr_d   = cap_en ? DbgAdr       : cap_adr_q;
      cap_wdata_d = cap_en ? DbgWdata     : cap_wdata_q;
      rsp_data_d  = rsp_en ? CSRMReadValM : rsp_data_q;
      rsp_err_d   = rsp_en ? illegal      : rsp_err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cap_write_q <= 1'b0;
         cap_adr_q   <= '0;
         cap_wdata_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_write_q <= cap_write_d;
         cap_adr_q   <= cap_adr_d;
         cap_wdata_q <= cap_wdata_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign DbgRspData = rsp_data_q;
   assign DbgRspErr  = rsp_err_q;

endmodule
